// File: rtl/rr_index_arbiter.sv
// rr_index_arbiter: round-robin arbiter over 2**N request lines.
// Produces a registered binary grant index with a valid/ready handshake.
// The index is meant to drive a downstream decoder's select input, with
// grant_valid driving its enable.
//
// Optional build macro RR_ARB_ONEHOT_EN adds a registered one-hot copy
// of the grant (grant_onehot). That copy is decoder-equivalent and is all
// zeros whenever grant_valid is low.
//
// Handshake: a grant is presented when grant_valid=1, and it is transferred
// on a rising edge where grant_valid=1 and grant_ready=1. While
// grant_valid=1 and grant_ready=0, grant_idx is held stable and req is
// ignored. grant_ready has no effect while grant_valid=0.
module rr_index_arbiter #(
   parameter int N = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [2**N-1:0] req,
   input  logic            grant_ready,
   output logic            grant_valid,
   output logic [N-1:0]    grant_idx
`ifdef RR_ARB_ONEHOT_EN
   ,
   output logic [2**N-1:0] grant_onehot
`endif
);

   localparam int W = 2**N;

   // The FSM state is a named signal so that checkers can bind to it.
   // GRANT is equivalent to grant_valid=1.
   typedef enum logic {IDLE, GRANT} state_t;

   state_t       state;
   logic [N-1:0] ptr;          // highest-priority requester for the next search
   logic [N-1:0] search_base;  // where the search starts on this edge
   logic [N-1:0] scan_idx;
   logic [N-1:0] win_idx;
   logic         win_found;

   // On an accept, the pointer moves past the current grant and the new winner
   // is searched from that moved position on the same edge. This allows
   // back-to-back grants.
   always_comb begin
      search_base = (state == GRANT) ? grant_idx + N'(1) : ptr;
   end

   // Scan from the highest offset down, so the lowest offset from the base wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = '0;
      for (int i = W - 1; i >= 0; i--) begin
         scan_idx = search_base + N'(i);
         if (req[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

`ifdef RR_ARB_ONEHOT_EN
   function automatic logic [W-1:0] to_onehot(input logic [N-1:0] idx);
      to_onehot      = '0;
      to_onehot[idx] = 1'b1;
   endfunction
`endif

   // Arbitration FSM. All outputs are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         ptr          <= '0;
         grant_valid  <= 1'b0;
         grant_idx    <= '0;
`ifdef RR_ARB_ONEHOT_EN
         grant_onehot <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  state        <= GRANT;
                  grant_valid  <= 1'b1;
                  grant_idx    <= win_idx;
`ifdef RR_ARB_ONEHOT_EN
                  grant_onehot <= to_onehot(win_idx);
`endif
               end
            end
            GRANT: begin
               if (grant_ready) begin
                  ptr <= grant_idx + N'(1);
                  if (win_found) begin
                     grant_idx    <= win_idx;
`ifdef RR_ARB_ONEHOT_EN
                     grant_onehot <= to_onehot(win_idx);
`endif
                  end else begin
                     // grant_idx keeps its last value after a drain.
                     state        <= IDLE;
                     grant_valid  <= 1'b0;
`ifdef RR_ARB_ONEHOT_EN
                     grant_onehot <= '0;
`endif
                  end
               end
            end
            default: begin
               state       <= IDLE;
               grant_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
